// File: rtl/ld3320_bus_pkg.sv
// Shared types and phase-length helper for the LD3320 8080-style bus master.
// FSM state encoding and the setup/strobe/hold phase selectors live here.
package ld3320_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_SETUP,
    ST_ADDR_STROBE,
    ST_ADDR_HOLD,
    ST_DATA_SETUP,
    ST_DATA_STROBE,
    ST_DATA_HOLD,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_NONE,
    PH_SETUP,
    PH_STROBE,
    PH_HOLD
  } phase_e;

  function automatic phase_e state_phase(input state_e s);
    case (s)
      ST_ADDR_SETUP,  ST_DATA_SETUP:  return PH_SETUP;
      ST_ADDR_STROBE, ST_DATA_STROBE: return PH_STROBE;
      ST_ADDR_HOLD,   ST_DATA_HOLD:   return PH_HOLD;
      default:                        return PH_NONE;
    endcase
  endfunction

  function automatic int unsigned phase_len(input phase_e ph,
                                            input int unsigned setup_cyc,
                                            input int unsigned strobe_cyc,
                                            input int unsigned hold_cyc);
    case (ph)
      PH_SETUP:  return setup_cyc;
      PH_STROBE: return strobe_cyc;
      PH_HOLD:   return hold_cyc;
      default:   return 0;
    endcase
  endfunction

endpackage

// File: rtl/ld3320_bus_master_if.sv
// Command/data handshake and LD3320 pad signals grouped as one bundle.
// The master modport is the bus-master view; slave is the sequencer/pad side.
interface ld3320_bus_master_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic              cmd_incr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] wdata;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              done;
  logic              busy;
  logic              bus_oe;
  logic [DATA_W-1:0] bus_dout;
  logic [DATA_W-1:0] bus_din;
  logic              A0;
  logic              CSB;
  logic              WRB;
  logic              RDB;

  modport master (
    input  cmd_valid, cmd_write, cmd_incr, cmd_addr, cmd_len, wdata, wdata_valid, bus_din,
    output cmd_ready, wdata_ready, rdata, rdata_valid, done, busy, bus_oe, bus_dout,
           A0, CSB, WRB, RDB
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_incr, cmd_addr, cmd_len, wdata, wdata_valid, bus_din,
    input  cmd_ready, wdata_ready, rdata, rdata_valid, done, busy, bus_oe, bus_dout,
           A0, CSB, WRB, RDB
  );
endinterface

// File: rtl/ld3320_phase_timer.sv
// Down-counter timing one setup/strobe/hold phase; loaded on state entry.
// last marks the final cycle of the phase and is suppressed while stalled.
module ld3320_phase_timer #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             stall,
  output logic             last
);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (!stall && count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign last = (count_q == CNT_W'(1)) && !stall;

endmodule

// File: rtl/ld3320_bus_master.sv
// LD3320 8080-style parallel bus master: address/data cycles with programmable
// setup/strobe/hold widths, incrementing or fixed-address bursts.
module ld3320_bus_master
  import ld3320_bus_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 1,
  parameter int unsigned HOLD_CYC   = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  ld3320_bus_master_if.master bus
);

  localparam int unsigned MAX_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic              write_q, incr_q, captured_q, captured_d;
  logic              accept, stall, capture, phase_last;

  logic              a0_q, csb_q, wrb_q, rdb_q, oe_q, wready_q, rvalid_q, done_q, busy_q;
  logic              a0_d, csb_d, wrb_d, rdb_d, oe_d, wready_d, rvalid_d, done_d, busy_d;
  logic [DATA_W-1:0] dout_q, dout_d, rdata_q, rdata_d;
  logic              addr_ph_d, data_ph_d;

  assign accept  = bus.cmd_valid && (state_q == ST_IDLE);
  // A write beat waits in DATA_SETUP until data arrives; the timer is frozen meanwhile.
  assign stall   = (state_q == ST_DATA_SETUP) && write_q && !captured_q && !bus.wdata_valid;
  assign capture = (state_q == ST_DATA_SETUP) && write_q && !captured_q &&  bus.wdata_valid;

  ld3320_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_d != state_q),
    .load_val (CNT_W'(phase_len(state_phase(state_d), SETUP_CYC, STROBE_CYC, HOLD_CYC))),
    .stall    (stall),
    .last     (phase_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: a default assignment at the top of every combinational block keeps
  // each output driven on all paths, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:        if (accept)     state_d = ST_ADDR_SETUP;
      ST_ADDR_SETUP:  if (phase_last) state_d = ST_ADDR_STROBE;
      ST_ADDR_STROBE: if (phase_last) state_d = ST_ADDR_HOLD;
      ST_ADDR_HOLD:   if (phase_last) state_d = ST_DATA_SETUP;
      ST_DATA_SETUP:  if (phase_last) state_d = ST_DATA_STROBE;
      ST_DATA_STROBE: if (phase_last) state_d = ST_DATA_HOLD;
      ST_DATA_HOLD:
        if (phase_last) begin
          if (beats_q == '0) state_d = ST_DONE;
          else if (incr_q)   state_d = ST_ADDR_SETUP;
          else               state_d = ST_DATA_SETUP;
        end
      ST_DONE:        state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    beats_d    = beats_q;
    captured_d = (state_d == ST_DATA_SETUP) && (captured_q || capture);
    if (accept) begin
      addr_d  = bus.cmd_addr;
      beats_d = bus.cmd_len;
    end else if (state_q == ST_DATA_HOLD && phase_last && beats_q != '0) begin
      beats_d = beats_q - 1'b1;
      if (incr_q) addr_d = addr_q + 1'b1;
    end
  end

  // Output registers are loaded from the next state so pins line up with the state.
  always_comb begin
    addr_ph_d = state_d inside {ST_ADDR_SETUP, ST_ADDR_STROBE, ST_ADDR_HOLD};
    data_ph_d = state_d inside {ST_DATA_SETUP, ST_DATA_STROBE, ST_DATA_HOLD};
    a0_d      = addr_ph_d;
    csb_d     = !(state_d == ST_ADDR_STROBE || state_d == ST_DATA_STROBE);
    wrb_d     = !(state_d == ST_ADDR_STROBE || (state_d == ST_DATA_STROBE && write_q));
    rdb_d     = !(state_d == ST_DATA_STROBE && !write_q);
    oe_d      = !(data_ph_d && !write_q);
    wready_d  = capture;
    done_d    = (state_d == ST_DONE);
    busy_d    = (state_d != ST_IDLE);
    dout_d    = dout_q;
    if (addr_ph_d)    dout_d = DATA_W'(addr_d);
    else if (capture) dout_d = bus.wdata;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    if (state_q == ST_DATA_STROBE && phase_last && !write_q) begin
      rdata_d  = bus.bus_din;
      rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      beats_q    <= '0;
      write_q    <= 1'b0;
      incr_q     <= 1'b0;
      captured_q <= 1'b0;
      a0_q       <= 1'b0;
      csb_q      <= 1'b1;
      wrb_q      <= 1'b1;
      rdb_q      <= 1'b1;
      oe_q       <= 1'b1;
      wready_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      dout_q     <= '0;
      rdata_q    <= '0;
    end else begin
      addr_q     <= addr_d;
      beats_q    <= beats_d;
      captured_q <= captured_d;
      if (accept) begin
        write_q <= bus.cmd_write;
        incr_q  <= bus.cmd_incr;
      end
      a0_q       <= a0_d;
      csb_q      <= csb_d;
      wrb_q      <= wrb_d;
      rdb_q      <= rdb_d;
      oe_q       <= oe_d;
      wready_q   <= wready_d;
      rvalid_q   <= rvalid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      dout_q     <= dout_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.cmd_ready   = (state_q == ST_IDLE);
  assign bus.A0          = a0_q;
  assign bus.CSB         = csb_q;
  assign bus.WRB         = wrb_q;
  assign bus.RDB         = rdb_q;
  assign bus.bus_oe      = oe_q;
  assign bus.bus_dout    = dout_q;
  assign bus.wdata_ready = wready_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rvalid_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;

endmodule

// File: doc/ld3320_bus_master.md
# ld3320_bus_master

Parametrised parallel-bus master for the LD3320 voice-recognition chip. It runs address/data cycles on the chip's 8080-style bus (A0, CSB, WRB, RDB, bidirectional data) with programmable setup, strobe and hold widths. It supports multi-beat bursts in incrementing-address or fixed-address (FIFO register) mode. It sits between the voice-control sequencer, which issues commands, and the top-level tristate pad on the chip data bus.

## Interface
Parameters:
- DATA_W, 8, data bus width
- ADDR_W, 8, register address width (address is driven on the data bus, so ADDR_W ≤ DATA_W)
- LEN_W, 4, burst length field width; max burst = 2^LEN_W beats
- SETUP_CYC, 1, cycles A0/data are stable before the strobe (≥1)
- STROBE_CYC, 1, cycles CSB plus WRB/RDB are held low (≥1)
- HOLD_CYC, 1, cycles after the strobe rises before the next phase (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write, 0 = read
- cmd_incr  in  1  1 = address increments per beat; 0 = fixed address
- cmd_addr  in  ADDR_W  start register address
- cmd_len  in  LEN_W  beats minus 1
- wdata  in  DATA_W  write beat data
- wdata_valid  in  1  wdata present
- wdata_ready  out  1  one-cycle pulse when a write beat is consumed
- rdata  out  DATA_W  read beat data
- rdata_valid  out  1  one-cycle pulse per read beat; no backpressure
- done  out  1  one-cycle pulse at end of command
- busy  out  1  high from accept until done
- bus_oe  out  1  1 = drive pad from bus_dout; 0 = input
- bus_dout  out  DATA_W  pad output data
- bus_din  in  DATA_W  pad input data
- A0, CSB, WRB, RDB  out  1 each  chip control pins

## Operation
- Command is accepted on cmd_valid && cmd_ready. All cmd_* fields are latched on that cycle. The beat counter loads cmd_len.
- States: IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, DATA_SETUP, DATA_STROBE, DATA_HOLD, DONE.
- Each SETUP/STROBE/HOLD state lasts exactly SETUP_CYC/STROBE_CYC/HOLD_CYC cycles. A write DATA_SETUP is extended while wdata_valid=0.
- Address phase:
  - A0=1, bus_oe=1, bus_dout = zero-extended current address.
  - In ADDR_STROBE: CSB=0, WRB=0.
- Write data phase:
  - A0=0, bus_oe=1.
  - wdata is captured into bus_dout, with a wdata_ready pulse, on the first DATA_SETUP cycle where wdata_valid=1. The setup count starts from that capture.
  - In DATA_STROBE: CSB=0, WRB=0.
- Read data phase:
  - A0=0, bus_oe=0 from DATA_SETUP through DATA_HOLD.
  - In DATA_STROBE: CSB=0, RDB=0.
  - bus_din is sampled on the last DATA_STROBE cycle. rdata and rdata_valid appear the next cycle.
- After DATA_HOLD:
  - beats remaining, incr mode: address += 1 (mod 2^ADDR_W), go to ADDR_SETUP.
  - beats remaining, fixed mode: go to DATA_SETUP (no new address phase).
  - last beat: go to DONE.
- DONE lasts one cycle: done=1, then IDLE.
- Outside strobe states: CSB=WRB=RDB=1.

## Timing
- Reset values:
  - CSB=WRB=RDB=1, A0=0, bus_oe=1, bus_dout=0.
  - rdata=0, rdata_valid=0, wdata_ready=0, done=0, busy=0, cmd_ready=1.
  - state IDLE, all counters 0.
- All outputs are registered, except cmd_ready = (state==IDLE).
- Latency for one beat, no write stall: accept at cycle T; ADDR_SETUP begins at T+1; done is high at T+1+2·(SETUP_CYC+STROBE_CYC+HOLD_CYC); cmd_ready is high the following cycle.
- Each extra beat adds:
  - S+W+H cycles in fixed mode;
  - 2·(S+W+H) cycles in incr mode.
- Write stall: every cycle wdata_valid=0 in DATA_SETUP adds one cycle. There is no timeout and the strobes stay high during the stall.
- cmd_valid during busy is ignored (cmd_ready=0). Back-to-back commands are possible one cycle after done.
- Reset mid-burst: immediately back to reset values. The strobe is released asynchronously. No done pulse, and the partial burst is discarded.
- cmd_len = 2^LEN_W−1 runs exactly 2^LEN_W beats. The incr address wraps 0xFF→0x00 at ADDR_W=8.

## Structure
- Package ld3320_bus_pkg holds:
  - the state enum;
  - phase-select constants (PH_SETUP, PH_STROBE, PH_HOLD);
  - a function returning the phase length for a given phase.
- Sub-module ld3320_phase_timer: a down-counter loaded with the phase length on state entry. It asserts a last flag when the count reaches 1 and holds while a stall input is high. The FSM, beat counter, address register and bus registers stay in the top module.

## Test plan
- Single write, S=W=H=1, addr 0x35, wdata 0xA5 valid early:
  - address phase: A0=1, bus_dout=0x35, WRB low 1 cycle;
  - then A0=0, bus_dout=0xA5, WRB low 1 cycle;
  - done at T+7.
- Single read, addr 0xB2, bus_din=0x5C during strobe, STROBE_CYC=3:
  - RDB low 3 cycles, bus_oe=0 during the data phase;
  - rdata=0x5C with one rdata_valid pulse;
  - done once.
- Incr write burst, addr 0xFE, cmd_len=2, data 0x11/0x22/0x33:
  - address phases 0xFE, 0xFF, 0x00;
  - three wdata_ready pulses.
- Fixed-mode read burst, addr 0x05, cmd_len=3:
  - exactly one address phase and four RDB strobes;
  - four rdata_valid pulses carrying the bus_din values.
- Write stall: wdata_valid low for 5 cycles in DATA_SETUP:
  - CSB/WRB stay high, bus_oe=1;
  - done delayed by exactly 5 cycles.
- Reset asserted during ADDR_STROBE of a burst:
  - CSB/WRB go high immediately, no done;
  - cmd_ready=1 after release;
  - the next command runs normally.
